// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 ping-pong frame buffer.
package hub75_pkg;

    typedef logic [2:0] rgb_t;

    localparam int DEF_COLS = 32;
    localparam int DEF_ROWS = 16;

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_FULL = 1'b1
    } wr_state_t;

endpackage

// File: rtl/hub75_bank_ram.sv
// One frame bank: single write port plus a registered dual read port returning
// the top-half and bottom-half pixels together.
module hub75_bank_ram
    import hub75_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int AW   = $clog2(COLS * ROWS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  rgb_t          i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr_top,
    input  logic [AW-1:0] i_raddr_bot,
    output rgb_t          o_rdata_top,
    output rgb_t          o_rdata_bot
);

    rgb_t r_mem [COLS*ROWS];
    rgb_t r_rdata_top;
    rgb_t r_rdata_bot;

    // No reset on storage or read registers so the array maps onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_top <= r_mem[i_raddr_top];
            r_rdata_bot <= r_mem[i_raddr_bot];
        end
    end

    assign o_rdata_top = r_rdata_top;
    assign o_rdata_bot = r_rdata_bot;

endmodule

// File: rtl/hub75_frame_buffer.sv
// Ping-pong frame store between a raster pixel producer and the HUB75 scan driver.
// The producer fills the back bank; banks swap only on the driver's frame_done.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   WR_FILL | back bank accepting pixels in raster order, wr_ready high
//   WR_FULL | back bank holds a complete frame, waiting for frame_done
module hub75_frame_buffer
    import hub75_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int CW   = 5,
    parameter int RW   = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic          i_wr_sof,
    input  rgb_t          i_wr_rgb,
    input  logic          i_rd_en,
    input  logic [RW-1:0] i_rd_row,
    input  logic [CW-1:0] i_rd_col,
    output rgb_t          o_rd_top_rgb,
    output rgb_t          o_rd_bot_rgb,
    output logic          o_rd_valid,
    input  logic          i_frame_done,
    output logic          o_swap_pulse,
    output logic          o_pending
);

    localparam int NPIX = COLS * ROWS;
    localparam int AW   = $clog2(NPIX);
    localparam int YW   = $clog2(ROWS);
    localparam int HALF = ROWS / 2;

    wr_state_t       r_state;
    logic [CW-1:0]   r_wx;
    logic [YW-1:0]   r_wy;
    logic            r_front_sel;
    logic            r_front_loaded;
    logic            r_pending;
    logic            r_wr_ready;
    logic            r_swap_pulse;

    logic            r_rd_valid;
    logic            r_rd_sel;
    logic            r_rd_loaded;

    logic            w_wr_fire;
    logic            w_wx_last;
    logic            w_wy_last;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_raddr_top;
    logic [AW-1:0]   w_raddr_bot;
    logic [1:0]      w_we;
    logic [1:0]      w_re;
    rgb_t            w_top [2];
    rgb_t            w_bot [2];
    rgb_t            w_sel_top;
    rgb_t            w_sel_bot;

    assign w_wr_fire = i_wr_valid & r_wr_ready;
    assign w_wx_last = (r_wx == CW'(COLS - 1));
    assign w_wy_last = (r_wy == YW'(ROWS - 1));

    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    assign w_waddr     = i_wr_sof ? '0 : (AW'(r_wy) * AW'(COLS) + AW'(r_wx));
    assign w_raddr_top = AW'(i_rd_row) * AW'(COLS) + AW'(i_rd_col);
    assign w_raddr_bot = (AW'(i_rd_row) + AW'(HALF)) * AW'(COLS) + AW'(i_rd_col);

    // Writes go to the back bank, reads to the front bank: never the same bank.
    assign w_we[0] = w_wr_fire &  r_front_sel;
    assign w_we[1] = w_wr_fire & ~r_front_sel;
    assign w_re[0] = i_rd_en   & ~r_front_sel;
    assign w_re[1] = i_rd_en   &  r_front_sel;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        hub75_bank_ram #(
            .COLS (COLS),
            .ROWS (ROWS),
            .AW   (AW)
        ) u_bank (
            .i_clk       (i_clk),
            .i_we        (w_we[g]),
            .i_waddr     (w_waddr),
            .i_wdata     (i_wr_rgb),
            .i_re        (w_re[g]),
            .i_raddr_top (w_raddr_top),
            .i_raddr_bot (w_raddr_bot),
            .o_rdata_top (w_top[g]),
            .o_rdata_bot (w_bot[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= WR_FILL;
            r_wx           <= '0;
            r_wy           <= '0;
            r_front_sel    <= 1'b0;
            r_front_loaded <= 1'b0;
            r_pending      <= 1'b0;
            r_wr_ready     <= 1'b1;
            r_swap_pulse   <= 1'b0;
        end else begin
            r_swap_pulse <= 1'b0;
            case (r_state)
                WR_FILL: begin
                    if (w_wr_fire) begin
                        if (i_wr_sof) begin
                            r_wx <= CW'(1);
                            r_wy <= '0;
                        end else if (w_wx_last && w_wy_last) begin
                            r_state    <= WR_FULL;
                            r_pending  <= 1'b1;
                            r_wr_ready <= 1'b0;
                        end else if (w_wx_last) begin
                            r_wx <= '0;
                            r_wy <= r_wy + 1'b1;
                        end else begin
                            r_wx <= r_wx + 1'b1;
                        end
                    end
                end
                WR_FULL: begin
                    if (i_frame_done) begin
                        r_state        <= WR_FILL;
                        r_front_sel    <= ~r_front_sel;
                        r_front_loaded <= 1'b1;
                        r_pending      <= 1'b0;
                        r_wr_ready     <= 1'b1;
                        r_wx           <= '0;
                        r_wy           <= '0;
                        r_swap_pulse   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WR_FILL;
                end
            endcase
        end
    end

    // Bank choice is frozen with the request, so a read racing a swap sees the old front.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_rd_loaded <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_sel    <= r_front_sel;
                r_rd_loaded <= r_front_loaded;
            end
        end
    end

    assign w_sel_top = r_rd_sel ? w_top[1] : w_top[0];
    assign w_sel_bot = r_rd_sel ? w_bot[1] : w_bot[0];

    // RAM read registers are unreset, so blank the outputs until a frame has been shown.
    assign o_rd_top_rgb = (r_rd_valid && r_rd_loaded) ? w_sel_top : '0;
    assign o_rd_bot_rgb = (r_rd_valid && r_rd_loaded) ? w_sel_bot : '0;
    assign o_rd_valid   = r_rd_valid;
    assign o_wr_ready   = r_wr_ready;
    assign o_swap_pulse = r_swap_pulse;
    assign o_pending    = r_pending;

endmodule

// File: doc/hub75_frame_buffer.md
Name: hub75_frame_buffer

Overview:
- Double-buffered (ping-pong) pixel store directly upstream of the HUB75 panel driver.
- A pixel producer (pattern generator or UART loader) streams one full frame in raster order into the back buffer.
- The panel driver reads top-half and bottom-half pixels of the front buffer by row address and column.
- Buffers swap only at a driver-signalled frame boundary, so the panel never shows a torn frame.

Parameters:
- COLS, 32, panel width in pixels.
- ROWS, 16, panel height in pixels; must be even; the driver scans ROWS/2 row addresses.
- CW, 5, column index width, clog2(COLS).
- RW, 3, row-address width, clog2(ROWS/2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer pixel valid.
- wr_ready  out  1  block accepts a pixel when wr_valid && wr_ready.
- wr_sof  in  1  qualifies the accepted pixel as pixel (0,0) of a new frame.
- wr_rgb  in  3  pixel colour {B,G,R}, 1 bit per channel.
- rd_en  in  1  driver read request.
- rd_row  in  RW  row address; top pixel at y=rd_row, bottom pixel at y=rd_row+ROWS/2.
- rd_col  in  CW  column index.
- rd_top_rgb  out  3  top-half pixel {B,G,R}.
- rd_bot_rgb  out  3  bottom-half pixel {B,G,R}.
- rd_valid  out  1  rd_top_rgb and rd_bot_rgb are valid this cycle.
- frame_done  in  1  single-cycle pulse from the driver at the end of a full scan; the only point where a swap may occur.
- swap_pulse  out  1  single-cycle pulse in the cycle after a swap.
- pending  out  1  back buffer holds a complete frame awaiting swap.

Behaviour:
- Storage:
  - Two banks, each COLS*ROWS x 3 bits.
  - Index = y*COLS + x.
  - Register front_sel selects the front bank; the back bank is ~front_sel.
- Reset values (all asynchronous):
  - front_sel=0, front_loaded=0, wr counters 0, pending=0.
  - wr_ready=1, rd_valid=0, rd_top_rgb=0, rd_bot_rgb=0, swap_pulse=0.
  - Memory contents are not reset.
- Write FSM, states FILL and FULL:
  - FILL:
    - wr_ready=1.
    - On each accepted pixel: write to the back bank at (wx,wy); advance wx; on wx=COLS-1, wrap wx to 0 and increment wy.
    - Accepted pixel with wr_sof=1: written at (0,0) regardless of the counters; counters then point to (1,0). A partial frame is abandoned silently.
    - Accepted pixel at (COLS-1,ROWS-1): go to FULL, pending=1.
  - FULL:
    - wr_ready=0; wr_valid is ignored.
    - On frame_done: front_sel toggles, front_loaded=1, pending=0, counters reset to 0, go to FILL.
    - swap_pulse=1 on the next cycle.
  - frame_done in FILL: ignored, no swap.
  - Last pixel accepted in the same cycle as frame_done: enter FULL; the swap waits for the next frame_done.
- Read path:
  - Latency 1: rd_en sampled at cycle N gives rd_valid=1 and data at cycle N+1. rd_valid=0 when rd_en was 0.
  - The bank is selected by front_sel as registered at cycle N. A read coincident with a swap returns old-front data.
  - Before the first swap (front_loaded=0): data outputs are 0, and rd_valid still follows rd_en.
  - Out-of-range reads need no special handling: with the default parameters all rd_row/rd_col codes are in range.
- Bank write and bank read never target the same bank in the same cycle, so no collision logic is required.

Decomposition:
- Package hub75_pkg holds:
  - rgb_t (3-bit {B,G,R}).
  - Default COLS/ROWS constants.
  - Write-state encoding WR_FILL=0, WR_FULL=1.
- One sub-module: hub75_bank_ram, a simple dual-port RAM with one write port and one registered read port of 2 pixels (top/bottom).
  - Instantiated twice.
  - Behavioural, inferable as distributed RAM.

Test Plan:
- Reset, then rd_en=1, rd_row=0, rd_col=0 -> rd_valid=1 next cycle, rd_top_rgb=0, rd_bot_rgb=0, pending=0, wr_ready=1.
- Stream 512 pixels with rgb=(y*COLS+x)%8 and wr_sof on the first pixel -> pending=1 and wr_ready=0 after the 512th pixel. Pulse frame_done -> swap_pulse the next cycle. Read row=3, col=5 -> top=(3*32+5)%8=5, bot=(11*32+5)%8=5.
- Hold FULL with wr_valid=1 for 20 cycles and no frame_done -> no writes; front data unchanged; pending stays 1.
- After 100 pixels, assert wr_sof with rgb=7, then stream the rest of the frame with rgb=1, then swap -> pixel (0,0)=7, every other pixel=1.
- rd_en in the same cycle as frame_done -> returned data comes from the old front bank. A read one cycle later returns new-bank data.
- Assert rst mid-frame (after 300 pixels) -> all outputs return to reset values immediately. Reads return 0 until a full frame is loaded and swapped.
